// File: rtl/lb_frame_ctrl_if.sv
// Upstream framed pixel stream: valid/ready handshake with start-of-frame and end-of-line markers.
// The source drives the beat, the frame controller returns ready.
interface lb_frame_ctrl_if #(
   parameter int DATA_W = 8
) ();
   logic [DATA_W-1:0] s_pixel;
   logic              s_valid;
   logic              s_sof;
   logic              s_eol;
   logic              s_ready;

   modport master (
      output s_pixel, s_valid, s_sof, s_eol,
      input  s_ready
   );

   modport slave (
      input  s_pixel, s_valid, s_sof, s_eol,
      output s_ready
   );
endinterface

// File: rtl/lb_frame_ctrl.sv
// Frame sequencer ahead of the 3x3 line-buffer window engine: checks frame geometry,
// clears the line buffer at frame start and forwards accepted pixels one clock later.
module lb_frame_ctrl #(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480
) (
   input  logic              clk,
   input  logic              rst_n,
   lb_frame_ctrl_if.slave    s,
   input  logic              m_ready,
   output logic [DATA_W-1:0] lb_pixel,
   output logic              lb_valid,
   output logic              lb_clr,
   output logic              busy,
   output logic              frame_done,
   output logic              err_sof,
   output logic              err_eol,
   output logic [15:0]       frame_cnt
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   typedef enum logic [1:0] {IDLE, CLEAR, ACTIVE} state_t;

   state_t        state;
   logic [CW-1:0] col;
   logic [RW-1:0] row;

   logic at_origin;
   logic sof_restart;
   logic accept;
   logic last_col;
   logic eol_bad;

   assign at_origin   = (col == '0) && (row == '0);
   // A sof away from the origin restarts the frame; that beat is held so CLEAR can run first.
   assign sof_restart = (state == ACTIVE) && s.s_valid && s.s_sof && !at_origin;

   assign s.s_ready = (state == IDLE)   ? !s.s_sof :
                      (state == ACTIVE) ? (m_ready && !(s.s_sof && !at_origin)) :
                                          1'b0;

   assign accept   = s.s_valid && s.s_ready;
   assign last_col = (col == COL_LAST);
   assign eol_bad  = (s.s_eol != last_col);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         col        <= '0;
         row        <= '0;
         lb_pixel   <= '0;
         lb_valid   <= 1'b0;
         lb_clr     <= 1'b0;
         frame_done <= 1'b0;
         err_sof    <= 1'b0;
         err_eol    <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         lb_valid   <= 1'b0;
         lb_clr     <= 1'b0;
         frame_done <= 1'b0;
         err_sof    <= 1'b0;
         err_eol    <= 1'b0;

         case (state)
            IDLE: begin
               if (s.s_valid && s.s_sof) begin
                  state <= CLEAR;
               end
            end

            CLEAR: begin
               lb_clr <= 1'b1;
               col    <= '0;
               row    <= '0;
               state  <= ACTIVE;
            end

            ACTIVE: begin
               if (sof_restart) begin
                  err_sof <= 1'b1;
                  state   <= CLEAR;
               end else if (accept) begin
                  lb_pixel <= s.s_pixel;
                  lb_valid <= 1'b1;
                  // A misplaced or missing eol still forwards the beat, then aborts the frame.
                  if (eol_bad) begin
                     err_eol <= 1'b1;
                     col     <= '0;
                     row     <= '0;
                     state   <= IDLE;
                  end else if (last_col) begin
                     col <= '0;
                     if (row == ROW_LAST) begin
                        row        <= '0;
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 16'd1;
                        state      <= IDLE;
                     end else begin
                        row <= row + 1'b1;
                     end
                  end else begin
                     col <= col + 1'b1;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lb_frame_ctrl.sv
// Directed bench for lb_frame_ctrl on a 4x3 frame; forwarded pixels are scoreboarded with
// their expected arrival cycle, pulses and counters are checked against fixed expectations.
module tb_lb_frame_ctrl;
   localparam int DATA_W = 8;
   localparam int IMG_W  = 4;
   localparam int IMG_H  = 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              m_ready = 1'b1;
   logic [DATA_W-1:0] lb_pixel;
   logic              lb_valid, lb_clr, busy, frame_done, err_sof, err_eol;
   logic [15:0]       frame_cnt;

   lb_frame_ctrl_if #(.DATA_W(DATA_W)) sif ();

   lb_frame_ctrl #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .s          (sif),
      .m_ready    (m_ready),
      .lb_pixel   (lb_pixel),
      .lb_valid   (lb_valid),
      .lb_clr     (lb_clr),
      .busy       (busy),
      .frame_done (frame_done),
      .err_sof    (err_sof),
      .err_eol    (err_eol),
      .frame_cnt  (frame_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DATA_W-1:0] pix;
      int                cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   n_valid = 0, n_clr = 0, n_done = 0, n_esof = 0, n_eeol = 0;
   int   b_valid, b_clr, b_done, b_esof, b_eeol;
   logic p_clr = 1'b0, p_done = 1'b0, p_esof = 1'b0, p_eeol = 1'b0;
   logic [15:0] p_cnt = '0;
   bit   tog = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: scoreboard pop, pulse widths, clear/valid exclusion, counter timing.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (lb_valid) begin
            n_valid++;
            if (sb.size() == 0) chk("lb_valid_unexpected", 32'(lb_valid), 32'd0);
            else begin
               e = sb.pop_front();
               chk("lb_pixel", 32'(lb_pixel), 32'(e.pix));
               chk("lb_latency", cyc, e.cyc);
            end
         end
         if (lb_clr) begin
            n_clr++;
            chk("lb_clr_width", 32'(p_clr), 32'd0);
            chk("clr_valid_overlap", 32'(lb_valid), 32'd0);
         end
         if (frame_done) begin
            n_done++;
            chk("frame_done_width", 32'(p_done), 32'd0);
            chk("frame_cnt_step", 32'(frame_cnt), 32'(16'(p_cnt + 16'd1)));
         end else if (frame_cnt !== p_cnt) begin
            chk("frame_cnt_hold", 32'(frame_cnt), 32'(p_cnt));
         end
         if (err_sof) begin
            n_esof++;
            chk("err_sof_width", 32'(p_esof), 32'd0);
         end
         if (err_eol) begin
            n_eeol++;
            chk("err_eol_width", 32'(p_eeol), 32'd0);
         end
      end
      p_clr  <= lb_clr;
      p_done <= frame_done;
      p_esof <= err_sof;
      p_eeol <= err_eol;
      p_cnt  <= frame_cnt;
   end

   task automatic snap();
      b_valid = n_valid; b_clr = n_clr; b_done = n_done; b_esof = n_esof; b_eeol = n_eeol;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Present one beat and hold it until accepted; fwd marks beats that must reach the line buffer.
   task automatic send_beat(input logic [DATA_W-1:0] pix, input logic sof, input logic eol,
                            input bit fwd, input int budget);
      int w;
      bit done;
      w = 0;
      done = 1'b0;
      sif.s_pixel = pix;
      sif.s_sof   = sof;
      sif.s_eol   = eol;
      sif.s_valid = 1'b1;
      while (!done) begin
         @(negedge clk);
         if (tog && !m_ready) chk("s_ready_m_low", 32'(sif.s_ready), 32'd0);
         if (sif.s_ready) begin
            if (fwd) sb.push_back('{pix, cyc + 1});
            done = 1'b1;
         end
         @(posedge clk);
         #1;
         if (tog) m_ready = !m_ready;
         if (!done) begin
            w++;
            if (w > budget) begin
               chk("accept_timeout", w, budget);
               done = 1'b1;
            end
         end
      end
      sif.s_valid = 1'b0;
      sif.s_sof   = 1'b0;
      sif.s_eol   = 1'b0;
   endtask

   task automatic send_frame(input logic [DATA_W-1:0] base);
      for (int r = 0; r < IMG_H; r++)
         for (int c = 0; c < IMG_W; c++)
            send_beat(base + DATA_W'(r * IMG_W + c), (r == 0) && (c == 0), c == IMG_W - 1, 1'b1, 8);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      sif.s_pixel = '0;
      sif.s_valid = 1'b0;
      sif.s_sof   = 1'b0;
      sif.s_eol   = 1'b0;
      rst_n = 1'b0;
      idle(2);
      chk("rst_lb_valid", 32'(lb_valid), 32'd0);
      chk("rst_lb_clr", 32'(lb_clr), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      chk("rst_lb_pixel", 32'(lb_pixel), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);
      chk("idle_s_ready", 32'(sif.s_ready), 32'd1);

      // Clean frame
      snap();
      send_frame(8'h10);
      idle(3);
      chk("t1_clr", n_clr - b_clr, 1);
      chk("t1_valid", n_valid - b_valid, 12);
      chk("t1_done", n_done - b_done, 1);
      chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
      chk("t1_busy", 32'(busy), 32'd0);
      chk("t1_errs", (n_esof - b_esof) + (n_eeol - b_eeol), 0);
      chk("t1_sb_empty", sb.size(), 0);

      // Same frame with m_ready toggling every cycle
      snap();
      tog = 1'b1;
      send_frame(8'h40);
      tog = 1'b0;
      m_ready = 1'b1;
      idle(3);
      chk("t2_valid", n_valid - b_valid, 12);
      chk("t2_done", n_done - b_done, 1);
      chk("t2_errs", (n_esof - b_esof) + (n_eeol - b_eeol), 0);
      chk("t2_frame_cnt", 32'(frame_cnt), 32'd2);
      chk("t2_sb_empty", sb.size(), 0);

      // Beats without sof in IDLE are consumed and dropped
      snap();
      for (int i = 0; i < 5; i++) send_beat(8'hA0 + 8'(i), 1'b0, i[0], 1'b0, 0);
      idle(2);
      chk("t3_dropped", n_valid - b_valid, 0);
      chk("t3_busy", 32'(busy), 32'd0);
      send_frame(8'h70);
      idle(3);
      chk("t3_valid", n_valid - b_valid, 12);
      chk("t3_done", n_done - b_done, 1);
      chk("t3_frame_cnt", 32'(frame_cnt), 32'd3);

      // eol at column 2 of row 1
      snap();
      for (int c = 0; c < IMG_W; c++) send_beat(8'h80 + 8'(c), c == 0, c == IMG_W - 1, 1'b1, 8);
      send_beat(8'h84, 1'b0, 1'b0, 1'b1, 8);
      send_beat(8'h85, 1'b0, 1'b0, 1'b1, 8);
      send_beat(8'h86, 1'b0, 1'b1, 1'b1, 8);
      chk("t4_err_eol_now", 32'(err_eol), 32'd1);
      chk("t4_busy", 32'(busy), 32'd0);
      idle(3);
      chk("t4_eeol", n_eeol - b_eeol, 1);
      chk("t4_done", n_done - b_done, 0);
      chk("t4_valid", n_valid - b_valid, 7);
      chk("t4_frame_cnt", 32'(frame_cnt), 32'd3);
      chk("t4_sb_empty", sb.size(), 0);

      // sof at row 1 col 1 restarts the frame from that beat
      snap();
      for (int c = 0; c < IMG_W; c++) send_beat(8'h90 + 8'(c), c == 0, c == IMG_W - 1, 1'b1, 8);
      send_beat(8'h94, 1'b0, 1'b0, 1'b1, 8);
      sif.s_pixel = 8'hC0;
      sif.s_sof   = 1'b1;
      sif.s_eol   = 1'b0;
      sif.s_valid = 1'b1;
      @(negedge clk);
      chk("t5_sof_stall", 32'(sif.s_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("t5_err_sof_now", 32'(err_sof), 32'd1);
      chk("t5_busy_clear", 32'(busy), 32'd1);
      send_frame(8'hC0);
      idle(3);
      chk("t5_esof", n_esof - b_esof, 1);
      chk("t5_clr", n_clr - b_clr, 2);
      chk("t5_done", n_done - b_done, 1);
      chk("t5_eeol", n_eeol - b_eeol, 0);
      chk("t5_valid", n_valid - b_valid, 17);
      chk("t5_frame_cnt", 32'(frame_cnt), 32'd4);
      chk("t5_sb_empty", sb.size(), 0);

      // Asynchronous reset in the middle of row 1
      for (int c = 0; c < IMG_W; c++) send_beat(8'hD0 + 8'(c), c == 0, c == IMG_W - 1, 1'b1, 8);
      send_beat(8'hD4, 1'b0, 1'b0, 1'b1, 8);
      send_beat(8'hD5, 1'b0, 1'b0, 1'b1, 8);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_lb_valid", 32'(lb_valid), 32'd0);
      chk("t6_lb_pixel", 32'(lb_pixel), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_frame_cnt", 32'(frame_cnt), 32'd0);
      chk("t6_pulses", 32'({lb_clr, frame_done, err_sof, err_eol}), 32'd0);
      sb.delete();
      idle(2);
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);
      snap();
      send_frame(8'hE0);
      idle(3);
      chk("t6_done", n_done - b_done, 1);
      chk("t6_clr", n_clr - b_clr, 1);
      chk("t6_errs", (n_esof - b_esof) + (n_eeol - b_eeol), 0);
      chk("t6_frame_cnt", 32'(frame_cnt), 32'd1);
      chk("t6_sb_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
